// File: rtl/serializer_tx.sv
// Bit-serial word transmitter: parallel word in via valid/ready, LSB-first
// bit stream out on data_out qualified by write_out strobes.
module serializer_tx #(
    parameter int WIDTH         = 8,
    parameter int STROBE_CYCLES = 1,
    parameter int GAP_CYCLES    = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic                       status_in,
    output logic                       data_out,
    output logic                       write_out,
    output logic                       busy_out,
    output logic [$clog2(WIDTH+1)-1:0] count_out
);

    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int CMAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_STATUS,
        DRIVE,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic              data_q, data_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;

    logic accept;
    logic strobe_done;
    logic gap_done;
    logic last_bit;

    assign accept      = (state_q == IDLE) && valid_in && ready_q;
    assign strobe_done = (cyc_q == CW'(STROBE_CYCLES - 1));
    assign gap_done    = (cyc_q == CW'(GAP_CYCLES - 1));
    assign last_bit    = (cnt_q == CNTW'(WIDTH));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            data_q  <= 1'b0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            data_q  <= data_d;
            write_q <= write_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:        if (accept) state_d = WAIT_STATUS;
            WAIT_STATUS: if (status_in) state_d = DRIVE;
            DRIVE:       if (strobe_done) state_d = GAP;
            GAP:         if (gap_done) state_d = last_bit ? IDLE : DRIVE;
            default:     state_d = IDLE;
        endcase
    end

    // ready lags the return to IDLE by one cycle so it rises after the final gap
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        cyc_d   = '0;
        data_d  = data_q;
        write_d = write_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        unique case (state_q)
            IDLE: begin
                ready_d = !accept;
                busy_d  = accept;
                write_d = 1'b0;
                data_d  = 1'b0;
                if (accept) begin
                    shift_d = data_in;
                    cnt_d   = '0;
                end
            end
            WAIT_STATUS: begin
                ready_d = 1'b0;
                busy_d  = 1'b1;
                write_d = status_in;
                if (status_in) data_d = shift_q[0];
            end
            DRIVE: begin
                if (strobe_done) begin
                    write_d = 1'b0;
                    cnt_d   = cnt_q + CNTW'(1);
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            GAP: begin
                if (!gap_done) begin
                    cyc_d = cyc_q + CW'(1);
                end else if (last_bit) begin
                    busy_d = 1'b0;
                    data_d = 1'b0;
                    cnt_d  = '0;
                end else begin
                    shift_d = shift_q >> 1;
                    data_d  = shift_q[1];
                    write_d = 1'b1;
                end
            end
            default: begin
                write_d = 1'b0;
            end
        endcase
    end

    assign ready_out = ready_q;
    assign busy_out  = busy_q;
    assign data_out  = data_q;
    assign write_out = write_q;
    assign count_out = cnt_q;

endmodule
